move_input_conditioner: RTL and testbench

//  Upstream stage of the MonumentValley top: turns raw DE1 push-buttons into the

---
 rtl/move_input_conditioner_if.sv | 13 +
 rtl/move_input_conditioner.sv | 134 +++++++++++++
 tb/tb_move_input_conditioner.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_input_conditioner_if.sv
// Board-side button inputs and game-side move/dir/activate outputs of the input conditioner.
// master: drives buttons, observes game inputs; slave: the conditioner itself.
interface move_input_conditioner_if;
    logic [3:0] key_n;
    logic       act_n;
    logic       move;
    logic [2:0] dir;
    logic       activate;
    logic       busy;

    modport master (output key_n, act_n, input move, dir, activate, busy);
    modport slave  (input key_n, act_n, output move, dir, activate, busy);
endinterface

// File: rtl/move_input_conditioner.sv
// Synchronises/debounces 4 direction keys + activate key into fixed move windows and activate pulses.
// Latency: raw key fall -> move/activate rise after DEBOUNCE_CYCLES+3 clock edges.
// No backpressure: presses arriving while a window or cooldown is in progress are dropped.
module move_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MOVE_CYCLES     = 4096,
    parameter int COOLDOWN_CYCLES = 65536
) (
    input logic                    clock,
    input logic                    resetn,
    move_input_conditioner_if.slave io
);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WIN_MAX = (MOVE_CYCLES > COOLDOWN_CYCLES) ? MOVE_CYCLES : COOLDOWN_CYCLES;
    localparam int CNT_W   = $clog2(WIN_MAX + 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MOVING, COOLDOWN} state_t;

    // Bit 4 is the activate key, bits 3:0 the direction keys (index == dir code).
    logic [4:0]      raw_in;
    logic [4:0]      sync1_q, sync2_q, deb_q, deb_prev_q;
    logic [DB_W-1:0] db_cnt_q [5];
    logic [4:0]      press;

    assign raw_in = {io.act_n, io.key_n};
    assign press  = deb_prev_q & ~deb_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            deb_q      <= '1;
            deb_prev_q <= '1;
            for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q    <= raw_in;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 5; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    deb_q[i]    <= ~deb_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             move_q, move_d, busy_q, busy_d, act_q;
    logic [2:0]       dir_q, dir_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        move_d  = move_q;
        busy_d  = busy_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (|press[3:0]) begin
                    state_d = MOVING;
                    move_d  = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    // Lowest key index wins on simultaneous presses.
                    if (press[0])      dir_d = 3'b000;
                    else if (press[1]) dir_d = 3'b001;
                    else if (press[2]) dir_d = 3'b010;
                    else               dir_d = 3'b011;
                end
            end
            MOVING: begin
                if (cnt_q == MOVE_LAST) begin
                    move_d = 1'b0;
                    cnt_d  = '0;
                    if (COOLDOWN_CYCLES == 0) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = COOLDOWN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COOLDOWN: begin
                if (cnt_q == COOL_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                move_d  = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            move_q  <= 1'b0;
            busy_q  <= 1'b0;
            dir_q   <= 3'b000;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            move_q  <= move_d;
            busy_q  <= busy_d;
            dir_q   <= dir_d;
            act_q   <= press[4];
        end
    end

    assign io.move     = move_q;
    assign io.dir      = dir_q;
    assign io.activate = act_q;
    assign io.busy     = busy_q;
endmodule

// File: tb/tb_move_input_conditioner.sv
// Scenario bench for move_input_conditioner with small timing parameters and a window-level model.
module tb_move_input_conditioner;
    localparam int DEB  = 4;
    localparam int MOVE = 8;
    localparam int COOL = 4;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    move_input_conditioner_if bus ();

    move_input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .MOVE_CYCLES     (MOVE),
        .COOLDOWN_CYCLES (COOL)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .io     (bus.slave)
    );

    always #5 clock = ~clock;

    // Reference model: an input is accepted once its synchronised value has disagreed with the
    // accepted level for DEB consecutive cycles; an accepted press opens a window of MOVE move
    // cycles plus COOL cooldown cycles, counted as elapsed cycles since the window opened.
    logic [4:0]  m_s1, m_s2, m_deb, m_pend;
    int          m_run [5];
    int          m_since;
    logic        m_move, m_busy, m_act;
    logic [2:0]  m_dir;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_s1 = '1; m_s2 = '1; m_deb = '1; m_pend = '0;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
            m_since = 0; m_move = 0; m_busy = 0; m_act = 0; m_dir = 3'b000;
        end else begin
            m_act = m_pend[4];
            if (!m_busy) begin
                if (|m_pend[3:0]) begin
                    m_since = 0;
                    m_busy  = 1;
                    for (int i = 3; i >= 0; i--) if (m_pend[i]) m_dir = 3'(i);
                end
            end else begin
                m_since++;
                if (m_since >= MOVE + COOL) m_busy = 0;
            end
            m_move = m_busy && (m_since < MOVE);
            m_pend = '0;
            for (int i = 0; i < 5; i++) begin
                if (m_s2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_deb[i] = ~m_deb[i];
                        m_run[i] = 0;
                        if (!m_deb[i]) m_pend[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {bus.act_n, bus.key_n};
        end
    end

    task automatic test_reset();
        bus.key_n = 4'hF;
        bus.act_n = 1'b1;
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        vectors++; if (bus.move !== 1'b0) begin miscompares++; $display("FAIL reset_move got=%b want=0", bus.move); end
        vectors++; if (bus.dir !== 3'b000) begin miscompares++; $display("FAIL reset_dir got=%b want=000", bus.dir); end
        vectors++; if (bus.activate !== 1'b0) begin miscompares++; $display("FAIL reset_activate got=%b want=0", bus.activate); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        resetn = 1'b1;
    endtask

    task automatic test_hold_left();
        int rise = -1;
        int mcnt = 0;
        int bcnt = 0;
        bus.key_n = 4'b1011;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            vectors++;
            if ({bus.move, bus.busy, bus.activate, bus.dir} !== {m_move, m_busy, m_act, m_dir}) begin
                miscompares++;
                $display("FAIL hold_left_model c=%0d got=%b want=%b", c, {bus.move, bus.busy, bus.activate, bus.dir}, {m_move, m_busy, m_act, m_dir});
            end
            if (bus.move) begin
                mcnt++;
                if (rise < 0) rise = c;
                vectors++; if (bus.dir !== 3'b010) begin miscompares++; $display("FAIL hold_left_dir c=%0d got=%b want=010", c, bus.dir); end
            end
            if (bus.busy) bcnt++;
            if (c == 20) bus.key_n = 4'hF;
        end
        vectors++; if (rise !== 7) begin miscompares++; $display("FAIL hold_left_latency got=%0d want=7", rise); end
        vectors++; if (mcnt !== MOVE) begin miscompares++; $display("FAIL hold_left_move_len got=%0d want=%0d", mcnt, MOVE); end
        vectors++; if (bcnt !== MOVE + COOL) begin miscompares++; $display("FAIL hold_left_busy_len got=%0d want=%0d", bcnt, MOVE + COOL); end
    endtask

    task automatic test_glitch();
        int mcnt = 0;
        int bcnt = 0;
        int rise = -1;
        bus.key_n = 4'b1110;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clock);
            vectors++;
            if ({bus.move, bus.busy, bus.activate, bus.dir} !== {m_move, m_busy, m_act, m_dir}) begin
                miscompares++;
                $display("FAIL glitch_model c=%0d got=%b want=%b", c, {bus.move, bus.busy, bus.activate, bus.dir}, {m_move, m_busy, m_act, m_dir});
            end
            if (c <= 15 && (bus.move || bus.busy)) bcnt++;
            if (c > 15 && bus.move) begin
                mcnt++;
                if (rise < 0) begin
                    rise = c;
                    vectors++; if (bus.dir !== 3'b000) begin miscompares++; $display("FAIL glitch_dir got=%b want=000", bus.dir); end
                end
            end
            if (c == 3 || c == 19) bus.key_n = 4'hF;
            if (c == 15) bus.key_n = 4'b1110;
        end
        vectors++; if (bcnt !== 0) begin miscompares++; $display("FAIL glitch_rejected active_cycles got=%0d want=0", bcnt); end
        vectors++; if (mcnt !== MOVE) begin miscompares++; $display("FAIL glitch_accept_len got=%0d want=%0d", mcnt, MOVE); end
        vectors++; if (rise !== 22) begin miscompares++; $display("FAIL glitch_accept_latency got=%0d want=22", rise); end
    endtask

    task automatic test_simultaneous();
        int mcnt = 0;
        int rises = 0;
        logic prev = 1'b0;
        bus.key_n = 4'b0110;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clock);
            vectors++;
            if ({bus.move, bus.busy, bus.activate, bus.dir} !== {m_move, m_busy, m_act, m_dir}) begin
                miscompares++;
                $display("FAIL simultaneous_model c=%0d got=%b want=%b", c, {bus.move, bus.busy, bus.activate, bus.dir}, {m_move, m_busy, m_act, m_dir});
            end
            if (bus.move && !prev) begin
                rises++;
                vectors++; if (bus.dir !== 3'b000) begin miscompares++; $display("FAIL simultaneous_dir got=%b want=000", bus.dir); end
            end
            if (bus.move) mcnt++;
            prev = bus.move;
            if (c == 10) bus.key_n = 4'hF;
        end
        vectors++; if (rises !== 1 || mcnt !== MOVE) begin miscompares++; $display("FAIL simultaneous_windows got=%0d/%0d want=1/%0d", rises, mcnt, MOVE); end
    endtask

    task automatic test_cooldown_drop();
        int rises = 0;
        int rise2 = -1;
        logic prev = 1'b0;
        bus.key_n = 4'b1101;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clock);
            vectors++;
            if ({bus.move, bus.busy, bus.activate, bus.dir} !== {m_move, m_busy, m_act, m_dir}) begin
                miscompares++;
                $display("FAIL cooldown_model c=%0d got=%b want=%b", c, {bus.move, bus.busy, bus.activate, bus.dir}, {m_move, m_busy, m_act, m_dir});
            end
            if (bus.move && !prev) begin
                rises++;
                if (c > 40) begin
                    rise2 = c;
                    vectors++; if (bus.dir !== 3'b001) begin miscompares++; $display("FAIL cooldown_repress_dir got=%b want=001", bus.dir); end
                end
            end
            prev = bus.move;
            if (c == 6 || c == 20 || c == 46) bus.key_n = 4'hF;
            if (c == 10 || c == 40) bus.key_n = 4'b1101;
        end
        vectors++; if (rises !== 2) begin miscompares++; $display("FAIL cooldown_window_count got=%0d want=2", rises); end
        vectors++; if (rise2 !== 47) begin miscompares++; $display("FAIL cooldown_repress_latency got=%0d want=47", rise2); end
    endtask

    task automatic test_activate();
        int acnt = 0;
        int apos = -1;
        int mcnt = 0;
        bus.key_n = 4'b1110;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clock);
            vectors++;
            if ({bus.move, bus.busy, bus.activate, bus.dir} !== {m_move, m_busy, m_act, m_dir}) begin
                miscompares++;
                $display("FAIL activate_model c=%0d got=%b want=%b", c, {bus.move, bus.busy, bus.activate, bus.dir}, {m_move, m_busy, m_act, m_dir});
            end
            if (bus.activate) begin acnt++; apos = c; end
            if (bus.move) mcnt++;
            if (c == 6) bus.key_n = 4'hF;
            if (c == 8) bus.act_n = 1'b0;
            if (c == 18) bus.act_n = 1'b1;
        end
        vectors++; if (acnt !== 1 || apos !== 15) begin miscompares++; $display("FAIL activate_pulse count=%0d at=%0d want=1 at 15", acnt, apos); end
        vectors++; if (mcnt !== MOVE) begin miscompares++; $display("FAIL activate_move_len got=%0d want=%0d", mcnt, MOVE); end
    endtask

    task automatic test_reset_mid();
        int rise = -1;
        bus.key_n = 4'b0111;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clock);
            vectors++;
            if ({bus.move, bus.busy, bus.activate, bus.dir} !== {m_move, m_busy, m_act, m_dir}) begin
                miscompares++;
                $display("FAIL reset_mid_model c=%0d got=%b want=%b", c, {bus.move, bus.busy, bus.activate, bus.dir}, {m_move, m_busy, m_act, m_dir});
            end
            if (c > 13 && bus.move && rise < 0) begin
                rise = c;
                vectors++; if (bus.dir !== 3'b011) begin miscompares++; $display("FAIL reset_mid_dir got=%b want=011", bus.dir); end
            end
            if (c == 10) begin
                resetn = 1'b0;
                #1;
                vectors++; if ({bus.move, bus.dir, bus.busy} !== 5'b0) begin miscompares++; $display("FAIL reset_mid_async got=%b want=00000", {bus.move, bus.dir, bus.busy}); end
            end
            if (c == 13) resetn = 1'b1;
            if (c == 30) bus.key_n = 4'hF;
        end
        vectors++; if (rise !== 20) begin miscompares++; $display("FAIL reset_mid_latency got=%0d want=20", rise); end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 1; c <= 500; c++) begin
            @(negedge clock);
            vectors++;
            if ({bus.move, bus.busy, bus.activate, bus.dir} !== {m_move, m_busy, m_act, m_dir}) begin
                miscompares++;
                $display("FAIL random_model c=%0d got=%b want=%b", c, {bus.move, bus.busy, bus.activate, bus.dir}, {m_move, m_busy, m_act, m_dir});
            end
            if (c > 440) begin
                bus.key_n = 4'hF;
                bus.act_n = 1'b1;
            end else if (hold == 0) begin
                bus.key_n = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
                bus.act_n = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
                hold = $urandom_range(1, 12);
            end else begin
                hold--;
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold_left();
        test_glitch();
        test_simultaneous();
        test_cooldown_drop();
        test_activate();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
